// File: rtl/arb_pkt_mux_if.sv
// arb_pkt_mux_if
//   Bundles the stream and arbiter signals around the packet mux.
//   master: the mux side (drives in_rdy, arb_req and the output slot).
//   slave : the surrounding environment (sources, arbiter, downstream sink).
// Signals
//   in_vld/in_data/in_last/in_rdy : per-channel input beats, channel i at [i*DW +: DW]
//   arb_req/arb_grant             : request vector out, one-hot grant back (same cycle)
//   out_vld/out_data/out_last/out_rdy : registered output beat
interface arb_pkt_mux_if #(
  parameter int WIDTH = 4,
  parameter int DW    = 32
);
  logic [WIDTH-1:0]    in_vld;
  logic [WIDTH*DW-1:0] in_data;
  logic [WIDTH-1:0]    in_last;
  logic [WIDTH-1:0]    in_rdy;
  logic [WIDTH-1:0]    arb_req;
  logic [WIDTH-1:0]    arb_grant;
  logic                out_vld;
  logic [DW-1:0]       out_data;
  logic                out_last;
  logic                out_rdy;

  modport master (
    input  in_vld, in_data, in_last, arb_grant, out_rdy,
    output in_rdy, arb_req, out_vld, out_data, out_last
  );

  modport slave (
    output in_vld, in_data, in_last, arb_grant, out_rdy,
    input  in_rdy, arb_req, out_vld, out_data, out_last
  );
endinterface

// File: rtl/arb_pkt_mux.sv
// arb_pkt_mux
//   Packet-aware N:1 stream mux working against an external round-robin
//   arbiter. In IDLE it requests for every valid channel (only when the output
//   slot can take a beat) and uses the same-cycle grant. A multi-beat packet
//   locks the winning channel until its last beat; the arbiter sees no request
//   while locked, so its priority advances once per packet.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : arb_pkt_mux_if master modport (input streams, arbiter, output slot)
//   busy       : 1 while a multi-beat packet holds the lock
//   lock_ch    : one-hot locked channel, 0 when idle
module arb_pkt_mux #(
  parameter int WIDTH = 4,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  arb_pkt_mux_if.master    bus,
  output logic             busy,
  output logic [WIDTH-1:0] lock_ch
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] lock_reg, lock_next;
  logic             out_vld_reg;
  logic             out_last_reg;
  logic [DW-1:0]    out_data_reg;

  logic             out_free;
  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] rdy;
  logic             xfer;
  logic             xfer_last;
  logic [WIDTH-1:0] grant_masked;
  logic [DW-1:0]    masked [WIDTH];
  logic [DW-1:0]    sel_data;

  // The slot can take a new beat when empty or when its beat leaves this cycle.
  assign out_free     = ~out_vld_reg | bus.out_rdy;
  assign grant_masked = bus.arb_grant & req;

  // Requests and ready are forced low while reset is asserted so the
  // arbiter never sees a request from a design that is being reset.
  always_comb begin
    state_next = state_reg;
    lock_next  = lock_reg;
    req        = '0;
    rdy        = '0;
    xfer       = 1'b0;
    xfer_last  = 1'b0;
    case (state_reg)
      IDLE: begin
        req = bus.in_vld & {WIDTH{out_free & rst_n}};
        rdy = grant_masked;
      end
      LOCK: begin
        rdy = lock_reg & bus.in_vld & {WIDTH{out_free & rst_n}};
      end
      default: ;
    endcase
    xfer      = |rdy;
    xfer_last = |(rdy & bus.in_last);
    if (xfer) begin
      if (state_reg == IDLE && !xfer_last) begin
        state_next = LOCK;
        lock_next  = rdy;
      end else if (state_reg == LOCK && xfer_last) begin
        // Re-arbitration happens the cycle after the last beat.
        state_next = IDLE;
        lock_next  = '0;
      end
    end
  end

  // AND-OR data mux keyed by the one-hot accept vector.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign masked[gi] = bus.in_data[gi*DW +: DW] & {DW{rdy[gi]}};
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sel_data = sel_data | masked[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      lock_reg     <= '0;
      out_vld_reg  <= 1'b0;
      out_last_reg <= 1'b0;
      out_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      lock_reg  <= lock_next;
      if (xfer) begin
        out_vld_reg  <= 1'b1;
        out_data_reg <= sel_data;
        out_last_reg <= xfer_last;
      end else if (bus.out_rdy) begin
        out_vld_reg <= 1'b0;
      end
    end
  end

  // A multi-hot grant would OR several channels together in the data mux.
  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_masked));

  assign bus.arb_req  = req;
  assign bus.in_rdy   = rdy;
  assign bus.out_vld  = out_vld_reg;
  assign bus.out_data = out_data_reg;
  assign bus.out_last = out_last_reg;
  assign busy         = (state_reg == LOCK);
  assign lock_ch      = lock_reg;

endmodule

// File: tb/tb_arb_pkt_mux.sv
// tb_arb_pkt_mux
//   Drives arb_pkt_mux with directed scenarios and a randomized run. A
//   round-robin arbiter lives in the bench as part of the environment; the
//   randomized run is checked against a transaction-level model.
module tb_arb_pkt_mux;
  localparam int W  = 4;
  localparam int DW = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         busy;
  logic [W-1:0] lock_ch;
  int           checks = 0;
  int           errors = 0;
  int           arb_ptr;

  arb_pkt_mux_if #(.WIDTH(W), .DW(DW)) bus ();

  arb_pkt_mux #(.WIDTH(W), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .lock_ch (lock_ch)
  );

  always #5 clk = ~clk;

  // Round-robin choice: first requesting channel at or after ptr, -1 if none.
  function automatic int rr_idx(input logic [W-1:0] req, input int ptr);
    for (int k = 0; k < W; k++) begin
      int c;
      c = (ptr + k) % W;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // Environment arbiter: combinational grant, pointer moves past the winner.
  always_comb begin
    int g;
    g = rr_idx(bus.arb_req, arb_ptr);
    bus.arb_grant = (g >= 0) ? (W'(1) << g) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) arb_ptr <= 0;
    else if (|bus.arb_req) arb_ptr <= (rr_idx(bus.arb_req, arb_ptr) + 1) % W;
  end

  task automatic set_ch(input int ch, input logic vld, input logic last, input logic [DW-1:0] d);
    bus.in_vld[ch]          = vld;
    bus.in_last[ch]         = last;
    bus.in_data[ch*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.in_vld  = '0;
    bus.in_last = '0;
    bus.in_data = '0;
    bus.out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.in_vld  = 4'hF;
    bus.in_last = 4'hF;
    bus.out_rdy = 1'b1;
    for (int i = 0; i < W; i++) bus.in_data[i*DW +: DW] = 32'hDEAD_0000 + i;
    @(negedge clk);
    #1;
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b expected 0", bus.out_vld); end
    checks++; if (bus.in_rdy !== 4'h0) begin errors++; $display("FAIL reset_in_rdy: got %h expected 0", bus.in_rdy); end
    checks++; if (bus.arb_req !== 4'h0) begin errors++; $display("FAIL reset_arb_req: got %h expected 0", bus.arb_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (lock_ch !== 4'h0) begin errors++; $display("FAIL reset_lock_ch: got %h expected 0", lock_ch); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", bus.out_last); end
    // Release with multi-beat packets so ch0 locks, then reset asynchronously.
    rst_n       = 1'b1;
    bus.in_last = 4'h0;
    @(negedge clk);
    #1;
    checks++; if (bus.out_vld !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL reset_pre_lock: got vld=%b busy=%b expected 1 1", bus.out_vld, busy); end
    $display("reset: ch0 beat %h loaded, lock_ch=%h", bus.out_data, lock_ch);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL reset_async_out_vld: got %b expected 0", bus.out_vld); end
    checks++; if (busy !== 1'b0 || lock_ch !== 4'h0) begin errors++; $display("FAIL reset_async_lock: got busy=%b lock=%h expected 0 0", busy, lock_ch); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_async_out_data: got %h expected 0", bus.out_data); end
    checks++; if (bus.arb_req !== 4'h0 || bus.in_rdy !== 4'h0) begin errors++; $display("FAIL reset_async_req: got req=%h rdy=%h expected 0 0", bus.arb_req, bus.in_rdy); end
  endtask

  task automatic test_single_rr();
    logic [W-1:0]  exp_rdy;
    logic [DW-1:0] exp_data;
    apply_reset();
    bus.out_rdy = 1'b1;
    for (int i = 0; i < W; i++) set_ch(i, 1'b1, 1'b1, 32'hA0 + i);
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_rdy = W'(1) << (k % W);
      checks++; if (bus.in_rdy !== exp_rdy) begin errors++; $display("FAIL rr_in_rdy[%0d]: got %h expected %h", k, bus.in_rdy, exp_rdy); end
      checks++; if (bus.arb_req !== 4'hF) begin errors++; $display("FAIL rr_arb_req[%0d]: got %h expected f", k, bus.arb_req); end
      @(negedge clk);
      exp_data = 32'hA0 + (k % W);
      checks++; if (bus.out_vld !== 1'b1 || bus.out_data !== exp_data) begin errors++; $display("FAIL rr_out[%0d]: got vld=%b data=%h expected 1 %h", k, bus.out_vld, bus.out_data, exp_data); end
      $display("rr: beat %0d data=%h", k, bus.out_data);
    end
  endtask

  task automatic test_lock();
    int            b1;
    bit            ch2_done;
    int            outs;
    logic [W-1:0]  acc;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_data;
    apply_reset();
    bus.out_rdy = 1'b1;
    b1 = 0; ch2_done = 0; outs = 0;
    exp_q = '{32'h100, 32'h101, 32'h102, 32'h200};
    for (int c = 0; c < 7; c++) begin
      set_ch(1, b1 < 3, b1 == 2, 32'h100 + b1);
      set_ch(2, !ch2_done, 1'b1, 32'h200);
      #1;
      if (c == 1 || c == 2) begin
        checks++; if (busy !== 1'b1 || lock_ch !== 4'b0010) begin errors++; $display("FAIL lock_busy[%0d]: got busy=%b lock=%h expected 1 2", c, busy, lock_ch); end
        checks++; if (bus.in_rdy !== 4'b0010) begin errors++; $display("FAIL lock_in_rdy[%0d]: got %h expected 2", c, bus.in_rdy); end
      end
      acc = bus.in_rdy & bus.in_vld;
      @(negedge clk);
      if (acc[1]) b1++;
      if (acc[2]) ch2_done = 1;
      if (bus.out_vld) begin
        outs++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL lock_extra_beat: got %h expected none", bus.out_data);
        end else begin
          exp_data = exp_q.pop_front();
          if (bus.out_data !== exp_data) begin errors++; $display("FAIL lock_out_data: got %h expected %h", bus.out_data, exp_data); end
        end
        $display("lock: out data=%h last=%b", bus.out_data, bus.out_last);
      end
    end
    checks++; if (outs !== 4) begin errors++; $display("FAIL lock_beat_count: got %0d expected 4", outs); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < W; i++) set_ch(i, 1'b0, 1'b1, 32'h0);
    set_ch(0, 1'b1, 1'b1, 32'h300);
    set_ch(1, 1'b1, 1'b1, 32'h301);
    bus.out_rdy = 1'b1;
    #1;
    checks++; if (bus.in_rdy !== 4'b0001) begin errors++; $display("FAIL bp_first: got %h expected 1", bus.in_rdy); end
    @(negedge clk);
    bus.out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (bus.out_vld !== 1'b1 || bus.out_data !== 32'h300) begin errors++; $display("FAIL bp_hold[%0d]: got vld=%b data=%h expected 1 300", k, bus.out_vld, bus.out_data); end
      checks++; if (bus.arb_req !== 4'h0 || bus.in_rdy !== 4'h0) begin errors++; $display("FAIL bp_quiet[%0d]: got req=%h rdy=%h expected 0 0", k, bus.arb_req, bus.in_rdy); end
      @(negedge clk);
    end
    bus.out_rdy = 1'b1;
    #1;
    checks++; if (bus.in_rdy !== 4'b0010) begin errors++; $display("FAIL bp_resume: got %h expected 2", bus.in_rdy); end
    @(negedge clk);
    checks++; if (bus.out_vld !== 1'b1 || bus.out_data !== 32'h301) begin errors++; $display("FAIL bp_next_out: got vld=%b data=%h expected 1 301", bus.out_vld, bus.out_data); end
    $display("backpressure: resumed with data=%h", bus.out_data);
    #1;
    checks++; if (bus.in_rdy !== 4'b0001) begin errors++; $display("FAIL bp_wrap: got %h expected 1", bus.in_rdy); end
  endtask

  task automatic test_bubble();
    int            b0;
    bit            ch3_done;
    int            outs;
    logic [W-1:0]  acc;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_data;
    apply_reset();
    bus.out_rdy = 1'b1;
    b0 = 0; ch3_done = 0; outs = 0;
    exp_q = '{32'h400, 32'h401, 32'h402, 32'h403, 32'h430};
    for (int c = 0; c < 10; c++) begin
      set_ch(0, (b0 < 4) && (c != 2) && (c != 3), b0 == 3, 32'h400 + b0);
      set_ch(3, !ch3_done, 1'b1, 32'h430);
      #1;
      if (c >= 1 && c <= 5) begin
        checks++; if (busy !== 1'b1 || lock_ch !== 4'b0001) begin errors++; $display("FAIL bubble_lock[%0d]: got busy=%b lock=%h expected 1 1", c, busy, lock_ch); end
        checks++; if (bus.in_rdy[3] !== 1'b0) begin errors++; $display("FAIL bubble_starve[%0d]: got %b expected 0", c, bus.in_rdy[3]); end
      end
      if (c == 2 || c == 3) begin
        checks++; if (bus.in_rdy !== 4'h0) begin errors++; $display("FAIL bubble_no_xfer[%0d]: got %h expected 0", c, bus.in_rdy); end
      end
      acc = bus.in_rdy & bus.in_vld;
      @(negedge clk);
      if (acc[0]) b0++;
      if (acc[3]) ch3_done = 1;
      if (bus.out_vld) begin
        outs++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bubble_extra_beat: got %h expected none", bus.out_data);
        end else begin
          exp_data = exp_q.pop_front();
          if (bus.out_data !== exp_data) begin errors++; $display("FAIL bubble_out_data: got %h expected %h", bus.out_data, exp_data); end
        end
        $display("bubble: out data=%h last=%b", bus.out_data, bus.out_last);
      end
    end
    checks++; if (outs !== 5) begin errors++; $display("FAIL bubble_beat_count: got %0d expected 5", outs); end
  endtask

  task automatic test_reset_mid();
    int           b2;
    logic [W-1:0] acc;
    apply_reset();
    bus.out_rdy = 1'b1;
    b2 = 0;
    for (int c = 0; c < 2; c++) begin
      set_ch(2, 1'b1, b2 == 3, 32'h500 + b2);
      #1;
      acc = bus.in_rdy & bus.in_vld;
      @(negedge clk);
      if (acc[2]) b2++;
    end
    checks++; if (busy !== 1'b1 || bus.out_data !== 32'h501) begin errors++; $display("FAIL midrst_pre: got busy=%b data=%h expected 1 501", busy, bus.out_data); end
    $display("midrst: beat 2 data=%h in slot, resetting", bus.out_data);
    set_ch(2, 1'b1, 1'b0, 32'h502);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_vld !== 1'b0 || lock_ch !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_clear: got vld=%b lock=%h busy=%b expected 0 0 0", bus.out_vld, lock_ch, busy); end
    checks++; if (bus.in_rdy !== 4'h0 || bus.arb_req !== 4'h0) begin errors++; $display("FAIL midrst_quiet: got rdy=%h req=%h expected 0 0", bus.in_rdy, bus.arb_req); end
    @(negedge clk);
    rst_n = 1'b1;
    set_ch(1, 1'b1, 1'b1, 32'h5F1);
    set_ch(2, 1'b1, 1'b1, 32'h5F0);
    #1;
    checks++; if (bus.in_rdy !== 4'b0010 || busy !== 1'b0) begin errors++; $display("FAIL midrst_restart: got rdy=%h busy=%b expected 2 0", bus.in_rdy, busy); end
    @(negedge clk);
    checks++; if (bus.out_vld !== 1'b1 || bus.out_data !== 32'h5F1) begin errors++; $display("FAIL midrst_out1: got vld=%b data=%h expected 1 5f1", bus.out_vld, bus.out_data); end
    #1;
    checks++; if (bus.in_rdy !== 4'b0100) begin errors++; $display("FAIL midrst_next: got %h expected 4", bus.in_rdy); end
    @(negedge clk);
    checks++; if (bus.out_data !== 32'h5F0 || bus.out_last !== 1'b1) begin errors++; $display("FAIL midrst_out2: got data=%h last=%b expected 5f0 1", bus.out_data, bus.out_last); end
    $display("midrst: restart delivered %h", bus.out_data);
  endtask

  // Randomized traffic against a transaction-level model: each source holds a
  // head beat of a packet of random length; the model decides which channel
  // may move each cycle from the lock / round-robin rules and tracks the slot.
  task automatic test_random();
    logic [DW-1:0] cur_data [W];
    logic          cur_last [W];
    int            rem      [W];
    int            m_lock, m_ptr, w;
    bit            m_vld, m_last;
    logic [DW-1:0] m_data;
    bit            m_free;
    logic [W-1:0]  exp_req, exp_rdy, exp_lock, acc;
    apply_reset();
    m_lock = -1; m_ptr = 0; m_vld = 0; m_last = 0; m_data = '0;
    for (int i = 0; i < W; i++) begin
      rem[i]      = $urandom_range(1, 4);
      cur_data[i] = {4'(i), 28'($urandom)};
      cur_last[i] = (rem[i] == 1);
    end
    for (int cyc = 0; cyc < 1000; cyc++) begin
      for (int i = 0; i < W; i++) set_ch(i, $urandom_range(0, 3) != 0, cur_last[i], cur_data[i]);
      bus.out_rdy = ($urandom_range(0, 3) != 0);
      #1;
      m_free = !m_vld || bus.out_rdy;
      if (m_lock < 0) begin
        exp_req = m_free ? bus.in_vld : '0;
        w = rr_idx(exp_req, m_ptr);
      end else begin
        exp_req = '0;
        w = (m_free && bus.in_vld[m_lock]) ? m_lock : -1;
      end
      exp_rdy  = (w >= 0) ? (W'(1) << w) : '0;
      exp_lock = (m_lock >= 0) ? (W'(1) << m_lock) : '0;
      checks++; if (bus.arb_req !== exp_req) begin errors++; $display("FAIL rnd_arb_req@%0d: got %h expected %h", cyc, bus.arb_req, exp_req); end
      checks++; if (bus.in_rdy !== exp_rdy) begin errors++; $display("FAIL rnd_in_rdy@%0d: got %h expected %h", cyc, bus.in_rdy, exp_rdy); end
      checks++; if (bus.out_vld !== m_vld) begin errors++; $display("FAIL rnd_out_vld@%0d: got %b expected %b", cyc, bus.out_vld, m_vld); end
      if (m_vld) begin
        checks++; if (bus.out_data !== m_data || bus.out_last !== m_last) begin errors++; $display("FAIL rnd_out_beat@%0d: got %h/%b expected %h/%b", cyc, bus.out_data, bus.out_last, m_data, m_last); end
      end
      checks++; if (busy !== (m_lock >= 0) || lock_ch !== exp_lock) begin errors++; $display("FAIL rnd_lock@%0d: got busy=%b lock=%h expected %b %h", cyc, busy, lock_ch, (m_lock >= 0), exp_lock); end
      if (bus.out_vld && bus.out_rdy) $display("rnd: cyc %0d out data=%h last=%b", cyc, bus.out_data, bus.out_last);
      acc = bus.in_rdy & bus.in_vld;
      // Model update for the coming clock edge.
      if (w >= 0) begin
        m_vld  = 1;
        m_data = cur_data[w];
        m_last = cur_last[w];
        if (m_lock < 0) begin
          m_ptr = (w + 1) % W;
          if (!cur_last[w]) m_lock = w;
        end else if (cur_last[w]) begin
          m_lock = -1;
        end
      end else if (bus.out_rdy) begin
        m_vld = 0;
      end
      @(negedge clk);
      for (int i = 0; i < W; i++) begin
        if (acc[i]) begin
          rem[i]--;
          if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
          cur_data[i] = {4'(i), 28'($urandom)};
          cur_last[i] = (rem[i] == 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_rr();
    test_lock();
    test_backpressure();
    test_bubble();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
